// File: rtl/byte_striping_pkg.sv
// Shared constants and helpers for the N-lane round-robin word striper.
package byte_striping_pkg;

  localparam int MAX_LANES = 8;

  // A request of zero lanes, or more lanes than exist, means "use every lane".
  function automatic int clamp_lanes(input int requested, input int num_lanes);
    return (requested == 0 || requested > num_lanes) ? num_lanes : requested;
  endfunction

  function automatic int lane_idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/stripe_lane_fifo.sv
// Per-lane first-word-fall-through buffer; head reads as zero while the lane is empty.
module stripe_lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_f,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk_f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage carries no reset; the head mux hides stale contents when empty.
  always_ff @(posedge clk_f) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_f) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_f) disable iff (reset) !(pop && empty));
`endif

endmodule

// File: rtl/byte_striping_n.sv
// Round-robin word striper across NUM_LANES independently drained lane FIFOs.
// Optional start-of-packet lane-0 alignment: define BYTE_STRIPING_SOP_ALIGN_EN.
module byte_striping_n
  import byte_striping_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                                 clk_f,
  input  logic                                 reset,
  input  logic [WIDTH-1:0]                     data_in,
  input  logic                                 valid_in,
`ifdef BYTE_STRIPING_SOP_ALIGN_EN
  input  logic                                 sop_in,
`endif
  output logic                                 ready_out,
  input  logic [$clog2(NUM_LANES+1)-1:0]       active_lanes,
  output logic [NUM_LANES*WIDTH-1:0]           lane_data,
  output logic [NUM_LANES-1:0]                 lane_valid,
  input  logic [NUM_LANES-1:0]                 lane_ready,
  output logic [lane_idx_width(NUM_LANES)-1:0] cur_lane
);

  localparam int LW = lane_idx_width(NUM_LANES);
  localparam int CW = $clog2(NUM_LANES+1);
  localparam int NW = $clog2(DEPTH+1);

  logic [LW-1:0]        tgt_lane;
  logic [CW-1:0]        act_cnt;
  logic [CW-1:0]        act_req;
  logic                 reset_q;
  logic                 accept;
  logic                 all_empty;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] empty;
  logic [NW-1:0]        count [NUM_LANES];

  function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] lane,
                                               input logic [CW-1:0] cnt);
    int n;
    n = int'(lane) + 1;
    return (n >= int'(cnt)) ? '0 : LW'(n);
  endfunction

  assign act_req = CW'(clamp_lanes(int'(active_lanes), NUM_LANES));

`ifdef BYTE_STRIPING_SOP_ALIGN_EN
  assign tgt_lane = sop_in ? '0 : cur_lane;
`else
  assign tgt_lane = cur_lane;
`endif

  // Readiness comes from registered occupancy only; lane_ready never reaches it.
  assign ready_out = !reset_q && !full[tgt_lane];
  assign accept    = valid_in && ready_out;
  assign all_empty = &empty;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign push[k]       = accept && (tgt_lane == LW'(k));
    assign lane_valid[k] = (count[k] != '0);
    assign pop[k]        = lane_valid[k] && lane_ready[k];

    stripe_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_f (clk_f),
      .reset (reset),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (data_in),
      .head  (lane_data[k*WIDTH +: WIDTH]),
      .count (count[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // A new lane count is only adopted once every lane has drained, so no
  // in-flight word ever lands out of order.
  always_ff @(posedge clk_f) begin
    reset_q <= reset;
    if (reset) begin
      cur_lane <= '0;
      act_cnt  <= act_req;
    end else if (accept) begin
      cur_lane <= next_lane(tgt_lane, act_cnt);
    end else if (all_empty && (act_req != act_cnt)) begin
      act_cnt  <= act_req;
      cur_lane <= '0;
    end
  end

endmodule

// File: doc/byte_striping_n.md
Name: byte_striping_n

Overview:
- Parametrised successor to the two-lane striper.
- Distributes one input word stream round-robin across NUM_LANES output lanes on a single clock. Each lane has its own buffer, and lanes drain independently through valid/ready handshakes.
- Sits in phy_tx between the upstream word source and the per-lane serialisers.
- Supports a runtime-selectable active lane count and backpressure in both directions.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_LANES, 4, number of physical lanes (2..8).
- DEPTH, 4, entries per lane FIFO (power of two, ≥2).

Ports:
- clk_f  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  input word.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block accepts data_in this cycle.
- active_lanes  input  $clog2(NUM_LANES+1)  requested number of lanes in use.
- lane_data  output  NUM_LANES*WIDTH  lane k head word at bits [k*WIDTH +: WIDTH].
- lane_valid  output  NUM_LANES  lane k FIFO non-empty.
- lane_ready  input  NUM_LANES  downstream consumes lane k head.
- cur_lane  output  $clog2(NUM_LANES)  lane that will receive the next accepted word.

Behaviour:
- Reset, while reset=1 at a clock edge:
  - All FIFOs emptied; cur_lane=0; lane_valid=0; lane_data=0; ready_out=0 during reset.
  - Active count register set to the clamped value of active_lanes.
- Clamping: active_lanes of 0 or >NUM_LANES is treated as NUM_LANES.
- Accept: a word is accepted when valid_in & ready_out.
- ready_out = !reset_q & !full[cur_lane], derived from registered occupancy only, with no combinational path from lane_ready.
- On accept: word pushed into FIFO[cur_lane]; cur_lane ← (cur_lane+1) mod active_count. Wrap-around from active_count-1 to 0.
- Non-accepted cycles: cur_lane holds.
- Latency: a word accepted at edge t is visible on lane_data/lane_valid after edge t (available to consumer in cycle t+1). No bypass of an empty FIFO.
- Lane output is first-word-fall-through:
  - lane_valid[k] = count[k]≠0.
  - lane_data[k] = head when valid, else all-zeros.
  - Pop on lane_valid[k] & lane_ready[k].
- Simultaneous push and pop on the same lane:
  - Count unchanged.
  - Allowed when not full.
  - When full, push is already blocked by ready_out, so the pop-only result is count-1.
- Lanes ≥ active_count receive no pushes and drain normally.
- Active count change:
  - The active count register loads the clamped active_lanes only when all FIFOs are empty and no accept occurs that cycle; cur_lane is then forced to 0.
  - Otherwise the change is deferred. Ordering on lanes is never disturbed mid-stream.
- Reset mid-operation: buffered words are discarded, with no partial outputs. First word after reset goes to lane 0.
- Full/empty: count ranges 0..DEPTH; pointers wrap modulo DEPTH. Pop from an empty FIFO and push into a full FIFO are impossible by construction; assertions are included under simulation only.

Optional Feature:
- Macro: BYTE_STRIPING_SOP_ALIGN_EN.
- Defined:
  - Extra input sop_in (1 bit).
  - An accepted word with sop_in=1 is steered to lane 0 regardless of cur_lane; cur_lane then becomes 1 mod active_count.
  - ready_out for that cycle uses full[0] instead of full[cur_lane].
- Undefined: port absent; strict round-robin only.

Decomposition:
- Package byte_striping_pkg:
  - MAX_LANES=8.
  - Function clamp_lanes(requested, NUM_LANES).
  - Function lane_idx_width(n)=$clog2(n).
- Sub-module stripe_lane_fifo (WIDTH, DEPTH):
  - FWFT FIFO with push, pop, head, count, full and empty.
  - Zero head when empty, synchronous active-high reset.
  - Instantiated NUM_LANES times by generate.

Test Plan:
- Round-robin: NUM_LANES=4, active_lanes=4, all lane_ready=1, push 0x00000001..0x00000008 back-to-back → lane0 gets 1,5; lane1 2,6; lane2 3,7; lane3 4,8; each appears one cycle after acceptance.
- Backpressure: lane_ready=0 on all lanes, DEPTH=4, stream 17 words → 16 accepted, ready_out=0 when cur_lane=0 with FIFO0 full; release lane_ready[0] → next word accepted the following cycle.
- Lane count change: stream with active_lanes=4, switch to 2 mid-stream → count unchanged until all FIFOs drain; then words 0xA,0xB,0xC alternate lane0,lane1,lane0; lanes 2,3 stay lane_valid=0.
- Clamp: active_lanes=0 and active_lanes=7 (NUM_LANES=4) → behaves as 4 lanes.
- Reset mid-stream: assert reset with 3 words buffered → lane_valid=0 and lane_data=0 next cycle; first post-reset word lands in lane 0.
- SOP align (macro defined, active_lanes=4): cur_lane=2, accept word 0x55 with sop_in=1 → 0x55 in lane 0, cur_lane=1.
